// File: rtl/bcd_seg_scan.sv
// Latches NUM_DIGITS packed BCD digits and scans them onto a common-anode 7-segment
// display with a one-clock blank gap per slot. Optional macro: LEADING_ZERO_BLANK_EN.
module bcd_seg_scan #(
    parameter int NUM_DIGITS  = 4,
    parameter int REFRESH_DIV = 4
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    load,
    input  logic [4*NUM_DIGITS-1:0] bcd_in,
    input  logic [NUM_DIGITS-1:0]   dp_in,
    output logic [6:0]              seg,
    output logic                    dp,
    output logic [NUM_DIGITS-1:0]   an,
    output logic                    bcd_err
);

    localparam int IDX_W = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;
    localparam int PRE_W = $clog2(REFRESH_DIV);
    localparam logic [IDX_W-1:0] IDX_LAST = IDX_W'(NUM_DIGITS - 1);
    localparam logic [PRE_W-1:0] PRE_LAST = PRE_W'(REFRESH_DIV - 1);

    logic [3:0]            dig_sh [NUM_DIGITS];
    logic [NUM_DIGITS-1:0] dp_sh;
    logic [PRE_W-1:0]      presc;
    logic [IDX_W-1:0]      idx;

    logic                  in_err;
    logic [NUM_DIGITS-1:0] supp;
    logic [NUM_DIGITS-1:0] an_nxt;
    logic [6:0]            seg_nxt;
    logic                  dp_nxt;

    function automatic logic [6:0] enc(input logic [3:0] d);
        case (d)
            4'd0:    enc = 7'h40;
            4'd1:    enc = 7'h79;
            4'd2:    enc = 7'h24;
            4'd3:    enc = 7'h30;
            4'd4:    enc = 7'h19;
            4'd5:    enc = 7'h12;
            4'd6:    enc = 7'h02;
            4'd7:    enc = 7'h78;
            4'd8:    enc = 7'h00;
            4'd9:    enc = 7'h10;
            default: enc = 7'h3F;
        endcase
    endfunction

    always_comb begin
        in_err = 1'b0;
        for (int i = 0; i < NUM_DIGITS; i++) begin
            if (bcd_in[4*i +: 4] > 4'd9) in_err = 1'b1;
        end
    end

`ifdef LEADING_ZERO_BLANK_EN
    logic high_zero;

    // Walk down from the top digit; a digit is suppressed while it and everything above is 0.
    always_comb begin
        high_zero = 1'b1;
        supp      = '0;
        for (int i = NUM_DIGITS - 1; i >= 0; i--) begin
            high_zero = high_zero & (dig_sh[i] == 4'd0);
            if (i != 0) supp[i] = high_zero;
        end
    end
`else
    always_comb begin
        supp = '0;
    end
`endif

    // Prescaler phase 0 is the anti-ghosting gap; suppressed digits also stay dark.
    always_comb begin
        an_nxt  = '1;
        seg_nxt = 7'h7F;
        dp_nxt  = 1'b1;
        if ((presc != '0) && !supp[idx]) begin
            an_nxt[idx] = 1'b0;
            seg_nxt     = enc(dig_sh[idx]);
            dp_nxt      = ~dp_sh[idx];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < NUM_DIGITS; i++) dig_sh[i] <= 4'd0;
            dp_sh   <= '0;
            presc   <= '0;
            idx     <= '0;
            an      <= '1;
            seg     <= 7'h7F;
            dp      <= 1'b1;
            bcd_err <= 1'b0;
        end else begin
            presc <= (presc == PRE_LAST) ? '0 : presc + 1'b1;
            if (presc == PRE_LAST) begin
                idx <= (idx == IDX_LAST) ? '0 : idx + 1'b1;
            end
            an  <= an_nxt;
            seg <= seg_nxt;
            dp  <= dp_nxt;
            if (load) begin
                for (int i = 0; i < NUM_DIGITS; i++) dig_sh[i] <= bcd_in[4*i +: 4];
                dp_sh   <= dp_in;
                bcd_err <= bcd_err | in_err;
            end
        end
    end

endmodule

// File: tb/tb_bcd_seg_scan.sv
// Directed bench for bcd_seg_scan (NUM_DIGITS=4, REFRESH_DIV=4); expected values are
// hand-derived from the scan timing. Honours LEADING_ZERO_BLANK_EN when defined.
module tb_bcd_seg_scan;

`ifdef LEADING_ZERO_BLANK_EN
    localparam bit LZB = 1'b1;
`else
    localparam bit LZB = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        load;
    logic [15:0] bcd_in;
    logic [3:0]  dp_in;
    logic [6:0]  seg;
    logic        dp;
    logic [3:0]  an;
    logic        bcd_err;

    int checks = 0;
    int errors = 0;

    bcd_seg_scan #(.NUM_DIGITS(4), .REFRESH_DIV(4)) dut (
        .clk     (clk),
        .rst     (rst),
        .load    (load),
        .bcd_in  (bcd_in),
        .dp_in   (dp_in),
        .seg     (seg),
        .dp      (dp),
        .an      (an),
        .bcd_err (bcd_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Inputs change and outputs are sampled on the falling edge.
    task automatic tick();
        @(negedge clk);
    endtask

    task automatic chk(input string tag, input logic [3:0] ea, input logic [6:0] es, input logic ed);
        checks++;
        assert (an === ea && seg === es && dp === ed)
        else begin
            errors++;
            $error("FAIL %s: an=%b seg=%h dp=%b, expected an=%b seg=%h dp=%b",
                   tag, an, seg, dp, ea, es, ed);
        end
    endtask

    task automatic chk_err(input string tag, input logic ee);
        checks++;
        assert (bcd_err === ee)
        else begin
            errors++;
            $error("FAIL %s: bcd_err=%b, expected %b", tag, bcd_err, ee);
        end
    endtask

    task automatic chk_blank(input string tag);
        chk(tag, 4'hF, 7'h7F, 1'b1);
    endtask

    task automatic chk_dig(input string tag, input int digit, input logic [6:0] es,
                           input logic ed, input bit sup);
        logic [3:0] ea;
        ea = 4'hF;
        if (LZB && sup) begin
            chk(tag, 4'hF, 7'h7F, 1'b1);
        end else begin
            ea[digit] = 1'b0;
            chk(tag, ea, es, ed);
        end
    endtask

    // One full slot: gap clock followed by three driven clocks.
    task automatic slot(input string tag, input int digit, input logic [6:0] es, input bit sup);
        tick();
        chk_blank({tag, "_gap"});
        repeat (3) begin
            tick();
            chk_dig(tag, digit, es, 1'b1, sup);
        end
    endtask

    initial begin
        rst    = 1'b1;
        load   = 1'b1;
        bcd_in = 16'h1234;
        dp_in  = 4'b0000;

        // Reset, with load asserted to confirm reset wins.
        tick();
        tick();
        chk_blank("reset");
        chk_err("reset_err", 1'b0);
        rst  = 1'b0;
        load = 1'b0;
        tick();
        chk_blank("post_rst_gap");
        tick();
        chk_dig("first_slot", 0, 7'h40, 1'b1, 1'b0);

        // Load 1234 mid digit-0 slot: seg changes one clock later.
        load   = 1'b1;
        bcd_in = 16'h1234;
        tick();
        chk_dig("load_latency", 0, 7'h40, 1'b1, 1'b0);
        load = 1'b0;
        tick();
        chk_dig("load_new", 0, 7'h19, 1'b1, 1'b0);

        slot("scan_d1", 1, 7'h30, 1'b0);
        slot("scan_d2", 2, 7'h24, 1'b0);
        slot("scan_d3", 3, 7'h79, 1'b0);
        slot("scan_d0", 0, 7'h19, 1'b0);
        slot("scan2_d1", 1, 7'h30, 1'b0);
        slot("scan2_d2", 2, 7'h24, 1'b0);

        // Load 5678 on the edge where idx wraps 3->0.
        tick();
        chk_blank("wrap_gap");
        tick();
        chk_dig("wrap_d3a", 3, 7'h79, 1'b1, 1'b0);
        tick();
        chk_dig("wrap_d3b", 3, 7'h79, 1'b1, 1'b0);
        load   = 1'b1;
        bcd_in = 16'h5678;
        tick();
        chk_dig("wrap_d3c", 3, 7'h79, 1'b1, 1'b0);
        load = 1'b0;
        slot("wrap_d0", 0, 7'h00, 1'b0);
        slot("wrap_d1", 1, 7'h78, 1'b0);
        slot("wrap_d2", 2, 7'h02, 1'b0);
        slot("wrap_d3", 3, 7'h12, 1'b0);

        // Invalid digit loaded during the digit-0 gap.
        load   = 1'b1;
        bcd_in = 16'h00A9;
        tick();
        chk_blank("inv_gap");
        chk_err("inv_err_set", 1'b1);
        load = 1'b0;
        repeat (3) begin
            tick();
            chk_dig("inv_d0", 0, 7'h10, 1'b1, 1'b0);
        end
        slot("inv_d1", 1, 7'h3F, 1'b0);
        slot("inv_d2", 2, 7'h40, 1'b1);
        slot("inv_d3", 3, 7'h40, 1'b1);

        // A valid load does not clear the sticky flag.
        load   = 1'b1;
        bcd_in = 16'h0009;
        tick();
        chk_blank("valid_gap");
        load = 1'b0;
        repeat (3) begin
            tick();
            chk_dig("valid_d0", 0, 7'h10, 1'b1, 1'b0);
        end
        chk_err("err_sticky", 1'b1);
        slot("valid_d1", 1, 7'h40, 1'b1);

        // Decimal point on digit 2, then reset in the middle of that slot.
        load  = 1'b1;
        dp_in = 4'b0100;
        tick();
        chk_blank("dp_gap");
        load = 1'b0;
        tick();
        chk_dig("dp_d2", 2, 7'h40, 1'b0, 1'b1);
        rst = 1'b1;
        tick();
        chk_blank("midrst");
        chk_err("midrst_err", 1'b0);
        rst = 1'b0;
        tick();
        chk_blank("midrst_gap");
        repeat (3) begin
            tick();
            chk_dig("midrst_d0", 0, 7'h40, 1'b1, 1'b0);
        end
        slot("midrst_d1", 1, 7'h40, 1'b1);
        slot("midrst_d2", 2, 7'h40, 1'b1);

`ifdef LEADING_ZERO_BLANK_EN
        // 0050: digits 3 and 2 suppressed, digits 1 and 0 shown.
        load   = 1'b1;
        bcd_in = 16'h0050;
        dp_in  = 4'b1111;
        tick();
        chk_blank("lzb_gap");
        load = 1'b0;
        repeat (3) begin
            tick();
            chk_dig("lzb_d3", 3, 7'h40, 1'b0, 1'b1);
        end
        tick();
        chk_blank("lzb_d0_gap");
        repeat (3) begin
            tick();
            chk_dig("lzb_d0", 0, 7'h40, 1'b0, 1'b0);
        end
        tick();
        chk_blank("lzb_d1_gap");
        repeat (3) begin
            tick();
            chk_dig("lzb_d1", 1, 7'h12, 1'b0, 1'b0);
        end
        slot("lzb_d2", 2, 7'h40, 1'b1);
        slot("lzb_d3b", 3, 7'h40, 1'b1);

        // 0000: only digit 0 is shown.
        load   = 1'b1;
        bcd_in = 16'h0000;
        dp_in  = 4'b0000;
        tick();
        chk_blank("lzb0_gap");
        load = 1'b0;
        repeat (3) begin
            tick();
            chk_dig("lzb0_d0", 0, 7'h40, 1'b1, 1'b0);
        end
        slot("lzb0_d1", 1, 7'h40, 1'b1);
        slot("lzb0_d2", 2, 7'h40, 1'b1);
        slot("lzb0_d3", 3, 7'h40, 1'b1);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
